// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, port owner, and
// the data word returned when a transaction is aborted.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_EX = 1'b1
  } owner_e;

  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and execute.
// Execute wins ties, but fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          ex_req,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  output logic          ex_ack,
  output logic [DW-1:0] ex_rdata,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ex_rdata_q, ex_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          ex_ack_q, ex_ack_d;
  logic          bus_err_q, bus_err_d;
  logic          starved;
  logic          grant_if;

  assign starved  = (starve_q == SW'(STARVE_LIMIT));
  assign grant_if = if_req && (!ex_req || starved);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ex_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
      if_ack_q    <= if_ack_d;
      ex_ack_q    <= ex_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
    if_ack_d    = 1'b0;
    ex_ack_d    = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || ex_req) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = BUSY;
          if (grant_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_EX;
            mem_we_d    = ex_we;
            mem_addr_d  = ex_addr;
            mem_wdata_d = ex_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (!starved) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end

      BUSY: begin
        // A real ack beats the timeout when both land in the same cycle.
        if (mem_ack || (tmo_q == 8'(TIMEOUT))) begin
          mem_req_d = 1'b0;
          bus_err_d = !mem_ack;
          state_d   = RESP;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : DW'(BUS_ERR_DATA);
          end else begin
            ex_ack_d   = 1'b1;
            ex_rdata_d = mem_ack ? mem_rdata : DW'(BUS_ERR_DATA);
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ex_ack    = ex_ack_q;
  assign ex_rdata  = ex_rdata_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
